acc_22bit_stream: RTL and testbench



---
 rtl/acc_22bit_stream_pkg.sv | 13 +
 rtl/acc_22bit_stream_fa.sv | 24 ++
 rtl/acc_22bit_stream.sv | 85 ++++++++
 tb/tb_acc_22bit_stream.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/acc_22bit_stream_pkg.sv
// Shared types and defaults for the 22-bit streaming burst accumulator.
package acc_22bit_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    localparam int ACC_WIDTH_DEFAULT = 22;
    localparam int CNT_W_DEFAULT     = 8;

endpackage

// File: rtl/acc_22bit_stream_fa.sv
// Ripple-carry adder with [width:1] indexing: bit 1 is the LSB, bit width the MSB.
module FA_22bit #(
    parameter int WIDTH = 22
) (
    input  logic [WIDTH:1] a,
    input  logic [WIDTH:1] b,
    input  logic           cin,
    output logic [WIDTH:1] s,
    output logic           cout
);

    logic carry;

    always_comb begin
        s     = '0;
        carry = cin;
        for (int i = 1; i <= WIDTH; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/acc_22bit_stream.sv
// Streaming burst accumulator: sums samples until in_last, then presents
// the total, saturating beat count and sticky overflow on a valid/ready port.
module acc_22bit_stream
    import acc_22bit_stream_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    acc_state_t       state;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             first;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_s;
    logic             add_c;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;

    assign in_ready = (state != HOLD) | out_ready;
    assign accept   = in_valid & in_ready;
    assign first    = (state == IDLE) | (state == HOLD);
    assign add_a    = first ? '0 : acc;

    FA_22bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (add_a),
        .b    (in_data),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_c)
    );

    // A new burst restarts overflow and count; the counter sticks at all-ones.
    assign ovf_next = first ? add_c : (ovf | add_c);
    assign cnt_next = first ? CNT_W'(1)
                    : ((cnt == '1) ? cnt : cnt + CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else if (accept) begin
            acc <= add_s;
            ovf <= ovf_next;
            cnt <= cnt_next;
            if (in_last) begin
                state     <= HOLD;
                out_valid <= 1'b1;
                out_sum   <= add_s;
                out_ovf   <= ovf_next;
                out_count <= cnt_next;
            end else begin
                state     <= ACC;
                out_valid <= 1'b0;
            end
        end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_22bit_stream.sv
// Directed bench for acc_22bit_stream: default instance plus a CNT_W=2 instance on shared inputs.
module tb_acc_22bit_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [21:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [21:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_count;

    logic        sm_in_ready;
    logic        sm_out_valid;
    logic [21:0] sm_out_sum;
    logic        sm_out_ovf;
    logic [1:0]  sm_out_count;

    int total_checks;
    int passed_checks;

    acc_22bit_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    acc_22bit_stream #(
        .WIDTH (22),
        .CNT_W (2)
    ) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (sm_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (sm_out_valid),
        .out_ready (out_ready),
        .out_sum   (sm_out_sum),
        .out_ovf   (sm_out_ovf),
        .out_count (sm_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one beat, pass a rising edge, and settle 1 time unit after it.
    task automatic applyStimulus(input logic v, input logic [21:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        rst_n = 1'b1;

        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sum",   32'(out_sum),   32'd0);
        checkOutput("rst_out_count", 32'(out_count), 32'd0);
        checkOutput("rst_out_ovf",   32'(out_ovf),   32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);

        // Burst 1,2,(gap),3 last
        applyStimulus(1'b1, 22'd1, 1'b0);
        checkOutput("b1_no_valid_mid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 22'd2, 1'b0);
        applyStimulus(1'b0, 22'h3ABCDE, 1'b1);
        checkOutput("b1_gap_no_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 22'd3, 1'b1);
        checkOutput("b1_valid", 32'(out_valid), 32'd1);
        checkOutput("b1_sum",   32'(out_sum),   32'd6);
        checkOutput("b1_count", 32'(out_count), 32'd3);
        checkOutput("b1_ovf",   32'(out_ovf),   32'd0);
        applyStimulus(1'b0, 22'd0, 1'b0);
        checkOutput("b1_consumed", 32'(out_valid), 32'd0);

        // Overflow burst, then a single-beat burst clears the sticky flag
        applyStimulus(1'b1, 22'h3FFFFF, 1'b0);
        applyStimulus(1'b1, 22'h000002, 1'b1);
        checkOutput("ovf_sum",   32'(out_sum),   32'h1);
        checkOutput("ovf_flag",  32'(out_ovf),   32'd1);
        checkOutput("ovf_count", 32'(out_count), 32'd2);
        applyStimulus(1'b1, 22'h10, 1'b1);
        checkOutput("single_sum",   32'(out_sum),   32'h10);
        checkOutput("single_ovf",   32'(out_ovf),   32'd0);
        checkOutput("single_count", 32'(out_count), 32'd1);
        applyStimulus(1'b0, 22'd0, 1'b0);

        // Backpressure: result 9 held while consumer stalls
        out_ready = 1'b0;
        applyStimulus(1'b1, 22'd4, 1'b0);
        applyStimulus(1'b1, 22'd5, 1'b1);
        checkOutput("hold_sum_first", 32'(out_sum), 32'd9);
        in_valid = 1'b1;
        in_data  = 22'h20;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            applyStimulus(1'b1, 22'h20, 1'b1);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_sum",   32'(out_sum),   32'd9);
            checkOutput("hold_count", 32'(out_count), 32'd2);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 22'h20, 1'b1);
        checkOutput("release_valid", 32'(out_valid), 32'd1);
        checkOutput("release_sum",   32'(out_sum),   32'h20);
        checkOutput("release_count", 32'(out_count), 32'd1);

        // Back-to-back single-beat bursts
        in_valid = 1'b1;
        in_data  = 22'd5;
        in_last  = 1'b1;
        #1;
        checkOutput("b2b_ready_0", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 22'd5, 1'b1);
        checkOutput("b2b_sum_5", 32'(out_sum), 32'd5);
        checkOutput("b2b_ready_1", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 22'd7, 1'b1);
        checkOutput("b2b_sum_7", 32'(out_sum), 32'd7);
        checkOutput("b2b_ready_2", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 22'd11, 1'b1);
        checkOutput("b2b_sum_11",   32'(out_sum),   32'd11);
        checkOutput("b2b_valid_11", 32'(out_valid), 32'd1);

        // Reset mid-burst discards the partial sum
        applyStimulus(1'b1, 22'd4, 1'b0);
        applyStimulus(1'b1, 22'd4, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_valid", 32'(out_valid), 32'd0);
        checkOutput("mrst_sum",   32'(out_sum),   32'd0);
        checkOutput("mrst_count", 32'(out_count), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        applyStimulus(1'b0, 22'd0, 1'b0);
        checkOutput("mrst_no_stale", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 22'd1, 1'b1);
        checkOutput("mrst_new_valid", 32'(out_valid), 32'd1);
        checkOutput("mrst_new_sum",   32'(out_sum),   32'd1);
        checkOutput("mrst_new_count", 32'(out_count), 32'd1);
        applyStimulus(1'b0, 22'd0, 1'b0);

        // Five beats of 1: the CNT_W=2 instance saturates at 3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 22'd1, (i == 4));
        end
        checkOutput("sat_small_count", 32'(sm_out_count), 32'd3);
        checkOutput("sat_small_sum",   32'(sm_out_sum),   32'd5);
        checkOutput("sat_small_valid", 32'(sm_out_valid), 32'd1);
        checkOutput("sat_main_count",  32'(out_count),    32'd5);
        checkOutput("sat_main_sum",    32'(out_sum),      32'd5);
        applyStimulus(1'b0, 22'd0, 1'b0);
        checkOutput("sat_consumed", 32'(sm_out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
